// File: rtl/pipe_stall_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipe_stall_ctrl_pkg
//   Shared types and constants for the 5-stage core's pipeline sequencing
//   controller and any block that consumes its stall vector.
//
//   Contents:
//     REG_W / ZERO_WORD  - architectural register width and its zero value
//     stall_bus_t        - per-stage stall vector [0]PC [1]IF [2]ID [3]EX
//                          [4]MEM [5]WB
//     STALL_NONE/ID/EX   - canonical stall masks; a stall in a stage always
//                          freezes every stage upstream of it as well
//     pc_state_e         - controller FSM states (IDLE / BUSY)
//     hazard_stall()     - stall mask produced by the ID load-use request
//
//   Optional feature macro used by the files that import this package:
//     PIPE_CTRL_STATS_EN - adds the stall-cycle statistics counter
// ----------------------------------------------------------------------------
package pipe_stall_ctrl_pkg;

    localparam int REG_W = 32;
    localparam logic [REG_W-1:0] ZERO_WORD = '0;

    localparam int STALL_W = 6;
    typedef logic [STALL_W-1:0] stall_bus_t;

    localparam stall_bus_t STALL_NONE = 6'b000000;
    localparam stall_bus_t STALL_ID   = 6'b000111;
    localparam stall_bus_t STALL_EX   = 6'b001111;

    typedef enum logic {
        PC_IDLE = 1'b0,
        PC_BUSY = 1'b1
    } pc_state_e;

    // An ID load-use hazard freezes PC, IF and ID; nothing downstream.
    function automatic stall_bus_t hazard_stall(input logic stallreq_id);
        return stallreq_id ? STALL_ID : STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipe_stall_ctrl_if
//   Bundles the hazard/flush requests coming from the pipeline and the
//   stall/flush/redirect controls going back to it.
//
//   Parameters:
//     MC_CNT_W  width of the multi-cycle op length
//     STAT_W    width of the stall-cycle statistics counter
//               (only present when PIPE_CTRL_STATS_EN is defined)
//
//   Signals (direction as seen by the controller):
//     stallreq_id_i   in   ID load-use hazard request
//     ex_mc_start_i   in   EX begins a multi-cycle op this cycle
//     ex_mc_len_i     in   total EX occupancy of the op (0 treated as 1)
//     flush_req_i     in   exception/ERET flush request
//     flush_pc_i      in   redirect target for the flush
//     stall_o         out  per-stage stall vector
//     flush_o         out  clear all pipeline registers this cycle
//     new_pc_o        out  redirect PC, zero unless flush_o is set
//     mc_busy_o       out  controller is in its BUSY state
//     mc_done_o       out  final EX cycle of a multi-cycle op
//     stall_cycles_o  out  saturating stall-cycle count (PIPE_CTRL_STATS_EN)
//
//   Modports:
//     master - the controller itself
//     slave  - the pipeline side that raises requests and obeys controls
// ----------------------------------------------------------------------------
interface pipe_stall_ctrl_if
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MC_CNT_W = 6
`ifdef PIPE_CTRL_STATS_EN
    , parameter int STAT_W = 32
`endif
);

    logic                stallreq_id_i;
    logic                ex_mc_start_i;
    logic [MC_CNT_W-1:0] ex_mc_len_i;
    logic                flush_req_i;
    logic [REG_W-1:0]    flush_pc_i;

    stall_bus_t          stall_o;
    logic                flush_o;
    logic [REG_W-1:0]    new_pc_o;
    logic                mc_busy_o;
    logic                mc_done_o;
`ifdef PIPE_CTRL_STATS_EN
    logic [STAT_W-1:0]   stall_cycles_o;
`endif

    modport master (
        input  stallreq_id_i,
        input  ex_mc_start_i,
        input  ex_mc_len_i,
        input  flush_req_i,
        input  flush_pc_i,
        output stall_o,
        output flush_o,
        output new_pc_o,
        output mc_busy_o,
`ifdef PIPE_CTRL_STATS_EN
        output stall_cycles_o,
`endif
        output mc_done_o
    );

    modport slave (
        output stallreq_id_i,
        output ex_mc_start_i,
        output ex_mc_len_i,
        output flush_req_i,
        output flush_pc_i,
        input  stall_o,
        input  flush_o,
        input  new_pc_o,
        input  mc_busy_o,
`ifdef PIPE_CTRL_STATS_EN
        input  stall_cycles_o,
`endif
        input  mc_done_o
    );

endinterface

// File: rtl/pipe_stall_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_stall_ctrl
//   Pipeline sequencing controller for the 5-stage core. Produces the
//   per-stage stall vector, the pipeline flush and the redirect PC.
//   Resolves ID load-use hazards, holds EX for multi-cycle ops (mul/div)
//   with an internal countdown, and applies exception/ERET flushes.
//   Priority: flush > EX multi-cycle > ID hazard.
//
//   Ports:
//     clk   in  core clock, all state on posedge
//     rst   in  asynchronous active-high reset; forces every output to 0
//               immediately
//     bus   pipe_stall_ctrl_if.master (requests in, controls out)
//
//   Parameters:
//     MC_CNT_W  width of the op length / countdown (max op 2^MC_CNT_W-1)
//     STAT_W    width of the stall-cycle counter (PIPE_CTRL_STATS_EN only)
//
//   Configuration macro:
//     PIPE_CTRL_STATS_EN - when defined, bus.stall_cycles_o counts cycles
//       with a non-zero stall vector, saturating at all-ones; cleared only
//       by rst. Flush cycles never stall, so they are never counted.
// ----------------------------------------------------------------------------
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MC_CNT_W = 6
`ifdef PIPE_CTRL_STATS_EN
    , parameter int STAT_W = 32
`endif
) (
    input  logic           clk,
    input  logic           rst,
    pipe_stall_ctrl_if.master bus
);

    localparam logic [MC_CNT_W-1:0] CNT_ONE = MC_CNT_W'(1);

    pc_state_e           state;
    pc_state_e           state_next;
    logic [MC_CNT_W-1:0] cnt;
    logic [MC_CNT_W-1:0] cnt_next;

    stall_bus_t          stall_raw;
    logic                flush_raw;
    logic [REG_W-1:0]    new_pc_raw;
    logic                done_raw;

    // State register and countdown. cnt holds the number of EX cycles still
    // owed to the op, including the release cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= PC_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state and control decode. A length of 0 or 1 means the op needs
    // no extra EX occupancy, so it completes in the issuing cycle and the ID
    // hazard request decides the stall, exactly as for a plain instruction.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stall_raw  = STALL_NONE;
        flush_raw  = 1'b0;
        new_pc_raw = ZERO_WORD;
        done_raw   = 1'b0;

        unique case (state)
            PC_IDLE: begin
                if (bus.flush_req_i) begin
                    flush_raw  = 1'b1;
                    new_pc_raw = bus.flush_pc_i;
                end else if (bus.ex_mc_start_i) begin
                    if (bus.ex_mc_len_i <= CNT_ONE) begin
                        done_raw  = 1'b1;
                        stall_raw = hazard_stall(bus.stallreq_id_i);
                    end else begin
                        stall_raw  = STALL_EX;
                        cnt_next   = bus.ex_mc_len_i - CNT_ONE;
                        state_next = PC_BUSY;
                    end
                end else begin
                    stall_raw = hazard_stall(bus.stallreq_id_i);
                end
            end

            PC_BUSY: begin
                if (bus.flush_req_i) begin
                    // Abort: the op never completes, so no done pulse.
                    flush_raw  = 1'b1;
                    new_pc_raw = bus.flush_pc_i;
                    cnt_next   = '0;
                    state_next = PC_IDLE;
                end else if (cnt > CNT_ONE) begin
                    // EX stall already covers PC/IF/ID, so an ID request is
                    // absorbed here.
                    stall_raw = STALL_EX;
                    cnt_next  = cnt - CNT_ONE;
                end else begin
                    done_raw   = 1'b1;
                    stall_raw  = hazard_stall(bus.stallreq_id_i);
                    cnt_next   = '0;
                    state_next = PC_IDLE;
                end
            end

            default: begin
                state_next = PC_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are combinational, but reset must silence them at once rather
    // than waiting for the state register to settle.
    assign bus.stall_o   = rst ? STALL_NONE : stall_raw;
    assign bus.flush_o   = rst ? 1'b0       : flush_raw;
    assign bus.new_pc_o  = rst ? ZERO_WORD  : new_pc_raw;
    assign bus.mc_done_o = rst ? 1'b0       : done_raw;
    assign bus.mc_busy_o = !rst && (state == PC_BUSY);

`ifdef PIPE_CTRL_STATS_EN
    logic [STAT_W-1:0] stall_cycles;

    // Saturating stall-cycle statistic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if ((stall_raw != STALL_NONE) && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + STAT_W'(1);
        end
    end

    assign bus.stall_cycles_o = stall_cycles;
`endif

    // Starting a new op while one is in flight is a protocol error by the
    // EX stage; the request is ignored by the decode above.
    mc_start_while_busy: assert property (
        @(posedge clk) disable iff (rst)
        !((state == PC_BUSY) && bus.ex_mc_start_i)
    );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_stall_ctrl
//   Self-checking bench for pipe_stall_ctrl. A reference model tracks the
//   cycle at which an in-flight op releases EX and derives the expected
//   outputs every cycle; directed sequences additionally pin hand-computed
//   values. Define PIPE_CTRL_STATS_EN to also cover the statistics counter
//   (built here with a 4-bit counter so saturation is reachable).
// ----------------------------------------------------------------------------
module tb_pipe_stall_ctrl;
    import pipe_stall_ctrl_pkg::*;

    localparam int MC_CNT_W = 6;
`ifdef PIPE_CTRL_STATS_EN
    localparam int STAT_W   = 4;
    localparam int STAT_MAX = (1 << STAT_W) - 1;
`endif

    logic clk = 1'b0;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef PIPE_CTRL_STATS_EN
    pipe_stall_ctrl_if #(.MC_CNT_W(MC_CNT_W), .STAT_W(STAT_W)) bus ();
    pipe_stall_ctrl #(.MC_CNT_W(MC_CNT_W), .STAT_W(STAT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`else
    pipe_stall_ctrl_if #(.MC_CNT_W(MC_CNT_W)) bus ();
    pipe_stall_ctrl #(.MC_CNT_W(MC_CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`endif

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge, then return at
    // the falling edge so the caller can sample settled outputs.
    task automatic applyStimulus(input logic id, input logic start, input logic [MC_CNT_W-1:0] len,
                                 input logic flush, input logic [31:0] pc);
        @(posedge clk);
        #1;
        bus.stallreq_id_i = id;
        bus.ex_mc_start_i = start;
        bus.ex_mc_len_i   = len;
        bus.flush_req_i   = flush;
        bus.flush_pc_i    = pc;
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 32'h0);
    endtask

    // ---------------- reference model and per-cycle compare ----------------
    int  cyc         = 0;
    bit  op_active   = 0;
    int  op_done_cyc = 0;
    int  stat_model  = 0;

    initial begin
        logic [31:0] e_stall, e_pc;
        logic        e_flush, e_busy, e_done;
        bit          n_active;
        int          n_done_cyc;
        int          op_len;
        forever begin
            @(negedge clk);
            e_stall    = 32'h0;
            e_pc       = 32'h0;
            e_flush    = 1'b0;
            e_busy     = 1'b0;
            e_done     = 1'b0;
            n_active   = op_active;
            n_done_cyc = op_done_cyc;
            if (rst) begin
                n_active = 0;
            end else begin
                e_busy = op_active;
                if (bus.flush_req_i) begin
                    e_flush  = 1'b1;
                    e_pc     = bus.flush_pc_i;
                    n_active = 0;
                end else if (op_active) begin
                    if (cyc < op_done_cyc) begin
                        e_stall = 32'h0F;
                    end else begin
                        e_done   = 1'b1;
                        e_stall  = bus.stallreq_id_i ? 32'h07 : 32'h00;
                        n_active = 0;
                    end
                end else if (bus.ex_mc_start_i) begin
                    op_len = (bus.ex_mc_len_i == 0) ? 1 : int'(bus.ex_mc_len_i);
                    if (op_len == 1) begin
                        e_done  = 1'b1;
                        e_stall = bus.stallreq_id_i ? 32'h07 : 32'h00;
                    end else begin
                        e_stall    = 32'h0F;
                        n_active   = 1;
                        n_done_cyc = cyc + op_len - 1;
                    end
                end else begin
                    e_stall = bus.stallreq_id_i ? 32'h07 : 32'h00;
                end
            end
            checkOutput("model_stall",  32'(bus.stall_o),   e_stall);
            checkOutput("model_flush",  32'(bus.flush_o),   32'(e_flush));
            checkOutput("model_new_pc", bus.new_pc_o,       e_pc);
            checkOutput("model_busy",   32'(bus.mc_busy_o), 32'(e_busy));
            checkOutput("model_done",   32'(bus.mc_done_o), 32'(e_done));
`ifdef PIPE_CTRL_STATS_EN
            checkOutput("model_stats",  32'(bus.stall_cycles_o), 32'(stat_model));
`endif
            @(posedge clk);
            if (rst) begin
                op_active  = 0;
                stat_model = 0;
            end else begin
                op_active   = n_active;
                op_done_cyc = n_done_cyc;
`ifdef PIPE_CTRL_STATS_EN
                if (e_stall != 0 && stat_model < STAT_MAX) stat_model++;
`endif
            end
            cyc++;
        end
    end

    // ---------------- directed sequences with literal pins ----------------
    initial begin
        rst               = 1'b1;
        bus.stallreq_id_i = 1'b0;
        bus.ex_mc_start_i = 1'b0;
        bus.ex_mc_len_i   = '0;
        bus.flush_req_i   = 1'b0;
        bus.flush_pc_i    = 32'h0;

        // Reset state.
        @(negedge clk);
        checkOutput("rst_stall", 32'(bus.stall_o),   32'h0);
        checkOutput("rst_busy",  32'(bus.mc_busy_o), 32'h0);
        checkOutput("rst_pc",    bus.new_pc_o,       32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // ID hazard for two cycles, then released.
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 32'h0);
        checkOutput("id_stall_c1", 32'(bus.stall_o), 32'h07);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 32'h0);
        checkOutput("id_stall_c2", 32'(bus.stall_o), 32'h07);
        idleCycle();
        checkOutput("id_release", 32'(bus.stall_o), 32'h00);

        // Length-4 op: three EX-stall cycles, released with done in cycle 4.
        applyStimulus(1'b0, 1'b1, 6'd4, 1'b0, 32'h0);
        checkOutput("len4_c1_stall", 32'(bus.stall_o),   32'h0F);
        checkOutput("len4_c1_busy",  32'(bus.mc_busy_o), 32'h0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 32'h0);
        checkOutput("len4_c2_stall", 32'(bus.stall_o),   32'h0F);
        checkOutput("len4_c2_busy",  32'(bus.mc_busy_o), 32'h1);
        idleCycle();
        checkOutput("len4_c3_stall", 32'(bus.stall_o),   32'h0F);
        idleCycle();
        checkOutput("len4_c4_stall", 32'(bus.stall_o),   32'h00);
        checkOutput("len4_c4_done",  32'(bus.mc_done_o), 32'h1);
        checkOutput("len4_c4_busy",  32'(bus.mc_busy_o), 32'h1);
        idleCycle();
        checkOutput("len4_after_busy", 32'(bus.mc_busy_o), 32'h0);
        checkOutput("len4_after_done", 32'(bus.mc_done_o), 32'h0);

        // Length 1 and length 0 complete in the issuing cycle.
        applyStimulus(1'b0, 1'b1, 6'd1, 1'b0, 32'h0);
        checkOutput("len1_stall", 32'(bus.stall_o),   32'h00);
        checkOutput("len1_done",  32'(bus.mc_done_o), 32'h1);
        applyStimulus(1'b0, 1'b1, 6'd0, 1'b0, 32'h0);
        checkOutput("len0_done",  32'(bus.mc_done_o), 32'h1);
        checkOutput("len0_busy",  32'(bus.mc_busy_o), 32'h0);
        applyStimulus(1'b1, 1'b1, 6'd1, 1'b0, 32'h0);
        checkOutput("len1_id_stall", 32'(bus.stall_o), 32'h07);
        idleCycle();
        checkOutput("len0_stays_idle", 32'(bus.mc_busy_o), 32'h0);

        // Length 2 with an ID request on the release cycle.
        applyStimulus(1'b0, 1'b1, 6'd2, 1'b0, 32'h0);
        checkOutput("len2_c1_stall", 32'(bus.stall_o), 32'h0F);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 32'h0);
        checkOutput("len2_c2_stall", 32'(bus.stall_o),   32'h07);
        checkOutput("len2_c2_done",  32'(bus.mc_done_o), 32'h1);

        // Flush in BUSY with cnt=3 aborts the op.
        applyStimulus(1'b0, 1'b1, 6'd5, 1'b0, 32'h0);
        idleCycle();
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 32'hBFC00380);
        checkOutput("flush_busy_flush", 32'(bus.flush_o),   32'h1);
        checkOutput("flush_busy_pc",    bus.new_pc_o,       32'hBFC00380);
        checkOutput("flush_busy_stall", 32'(bus.stall_o),   32'h00);
        checkOutput("flush_busy_done",  32'(bus.mc_done_o), 32'h0);
        checkOutput("flush_busy_busy",  32'(bus.mc_busy_o), 32'h1);
        idleCycle();
        checkOutput("flush_then_idle", 32'(bus.mc_busy_o), 32'h0);
        checkOutput("flush_pc_zero",   bus.new_pc_o,       32'h0);

        // Flush in IDLE beats a simultaneous start.
        applyStimulus(1'b1, 1'b1, 6'd6, 1'b1, 32'h80000180);
        checkOutput("flush_idle_pc",    bus.new_pc_o,     32'h80000180);
        checkOutput("flush_idle_stall", 32'(bus.stall_o), 32'h00);
        idleCycle();
        checkOutput("flush_idle_nobusy", 32'(bus.mc_busy_o), 32'h0);

        // Reset asserted mid-BUSY with cnt=5.
        applyStimulus(1'b0, 1'b1, 6'd7, 1'b0, 32'h0);
        idleCycle();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.stallreq_id_i = 1'b1;
        #1;
        checkOutput("rst_mid_stall", 32'(bus.stall_o),   32'h00);
        checkOutput("rst_mid_busy",  32'(bus.mc_busy_o), 32'h0);
        checkOutput("rst_mid_done",  32'(bus.mc_done_o), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.stallreq_id_i = 1'b0;
        @(negedge clk);
        checkOutput("rst_after_busy",  32'(bus.mc_busy_o), 32'h0);
        checkOutput("rst_after_stall", 32'(bus.stall_o),   32'h00);

`ifdef PIPE_CTRL_STATS_EN
        // Fresh reset, 3 ID stalls + a length-5 op => 7 counted cycles.
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) applyStimulus(1'b1, 1'b0, '0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 6'd5, 1'b0, 32'h0);
        repeat (4) idleCycle();
        idleCycle();
        checkOutput("stats_seven", 32'(bus.stall_cycles_o), 32'd7);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 32'h1234);
        idleCycle();
        checkOutput("stats_no_flush", 32'(bus.stall_cycles_o), 32'd7);
        applyStimulus(1'b0, 1'b1, 6'd20, 1'b0, 32'h0);
        repeat (20) idleCycle();
        checkOutput("stats_saturate", 32'(bus.stall_cycles_o), 32'(STAT_MAX));
`endif

        repeat (2) idleCycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
